// File: rtl/music_player_core.sv
// Transport FSM, frame-strobe sync, tempo-selectable beat generator and
// saturating multi-voice mixer feeding the codec one sample per frame.
module music_player_core #(
   parameter int NUM_SONGS  = 4,
   parameter int VOICES     = 3,
   parameter int SAMPLE_W   = 18,
   parameter int BEAT_COUNT = 1000,
   parameter int BEAT_W     = 11
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         play_button,
   input  logic                         next_button,
   input  logic [1:0]                   tempo,
   input  logic                         song_done,
   input  logic                         new_frame,
   input  logic [VOICES*SAMPLE_W-1:0]   voice_sample,
   input  logic [VOICES-1:0]            voice_valid,
   output logic                         play,
   output logic [$clog2(NUM_SONGS)-1:0] current_song,
   output logic                         reset_player,
   output logic                         generate_next_sample,
   output logic                         new_sample_generated,
   output logic                         beat,
   output logic [SAMPLE_W-1:0]          sample_out,
   output logic                         clip,
   output logic                         underrun
);
   localparam int SONG_W = $clog2(NUM_SONGS);
   localparam int SUM_W  = SAMPLE_W + $clog2(VOICES) + 1;
   localparam logic signed [SUM_W-1:0] SAT_MAX =
      {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_MIN =
      {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

   function automatic logic signed [SAMPLE_W-1:0] sat_value(input logic signed [SUM_W-1:0] s);
      if (s > SAT_MAX)      sat_value = {1'b0, {(SAMPLE_W-1){1'b1}}};
      else if (s < SAT_MIN) sat_value = {1'b1, {(SAMPLE_W-1){1'b0}}};
      else                  sat_value = s[SAMPLE_W-1:0];
   endfunction

   function automatic logic sat_flag(input logic signed [SUM_W-1:0] s);
      sat_flag = (s > SAT_MAX) || (s < SAT_MIN);
   endfunction

   typedef enum logic [1:0] {PAUSED, PLAYING, NEXT} state_t;
   state_t state, next_state;

   always_comb begin
      next_state = state;
      case (state)
         PAUSED: begin
            if (next_button)      next_state = NEXT;
            else if (play_button) next_state = PLAYING;
         end
         PLAYING: begin
            if (next_button || song_done) next_state = NEXT;
            else if (play_button)         next_state = PAUSED;
         end
         default: next_state = PAUSED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= PAUSED;
         current_song <= '0;
      end else begin
         state <= next_state;
         if (next_state == NEXT)
            current_song <= (current_song == SONG_W'(NUM_SONGS-1)) ? '0
                                                                    : current_song + SONG_W'(1);
      end
   end

   assign play         = (state == PLAYING);
   assign reset_player = (state == NEXT);

   // frame strobe: edge-detect, registered so the pulse is one clean cycle
   logic nf_p0, gen_p1;
   always_ff @(posedge clk) begin
      if (!reset) begin
         nf_p0  <= 1'b0;
         gen_p1 <= 1'b0;
      end else begin
         nf_p0  <= new_frame;
         gen_p1 <= new_frame & ~nf_p0;
      end
   end

   assign generate_next_sample = gen_p1;
   assign new_sample_generated = gen_p1;

   logic [BEAT_W-1:0] beat_cnt;
   logic [BEAT_W:0]   stop;
   logic              beat_hit, advance;

   always_comb begin
      case (tempo)
         2'b01:   stop = (BEAT_W+1)'(BEAT_COUNT/2);
         2'b10:   stop = (BEAT_W+1)'(2*BEAT_COUNT);
         default: stop = (BEAT_W+1)'(BEAT_COUNT);
      endcase
   end

   // >= rather than == so a tempo switch to a shorter beat never skips one
   assign beat_hit = ({1'b0, beat_cnt} >= (stop - {{BEAT_W{1'b0}}, 1'b1}));
   assign advance  = gen_p1 & play;
   assign beat     = advance & beat_hit;

   always_ff @(posedge clk) begin
      if (!reset)       beat_cnt <= '0;
      else if (advance) beat_cnt <= beat_hit ? '0 : beat_cnt + BEAT_W'(1);
   end

   // stage p0: per-voice capture
   logic signed [SAMPLE_W-1:0] voice_p0 [VOICES];
   logic [VOICES-1:0]          seen_p0;

   always_ff @(posedge clk) begin
      for (int i = 0; i < VOICES; i++)
         if (voice_valid[i]) voice_p0[i] <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
   end

   logic signed [SUM_W-1:0] sum_p0;
   always_comb begin
      sum_p0 = '0;
      for (int i = 0; i < VOICES; i++)
         sum_p0 = sum_p0 + {{(SUM_W-SAMPLE_W){voice_p0[i][SAMPLE_W-1]}}, voice_p0[i]};
      if (!play) sum_p0 = '0;
   end

   // stage p1: saturated mix waiting for the next frame strobe
   logic signed [SAMPLE_W-1:0] pending_p1;
   logic                       pending_ok_p1;
   logic                       mix_go;

   assign mix_go = (&seen_p0) & ~pending_ok_p1 & ~gen_p1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         seen_p0       <= '0;
         pending_p1    <= '0;
         pending_ok_p1 <= 1'b0;
         sample_out    <= '0;
         clip          <= 1'b0;
         underrun      <= 1'b0;
      end else begin
         clip     <= 1'b0;
         underrun <= 1'b0;
         if (gen_p1) begin
            seen_p0       <= voice_valid;
            pending_ok_p1 <= 1'b0;
            if (pending_ok_p1) sample_out <= pending_p1;
            else               underrun   <= 1'b1;
         end else begin
            seen_p0 <= seen_p0 | voice_valid;
            if (mix_go) begin
               pending_p1    <= sat_value(sum_p0);
               pending_ok_p1 <= 1'b1;
               clip          <= sat_flag(sum_p0);
            end
         end
      end
   end
endmodule

// File: tb/tb_music_player_core.sv
// Directed bench for music_player_core: transport table, beat tempo sequences,
// mixer saturation/underrun/muting and mid-frame reset.
module tb_music_player_core;
   localparam int NS = 4;
   localparam int NV = 3;
   localparam int SW = 18;
   localparam int BC = 8;
   localparam int BW = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              play_button, next_button, song_done, new_frame;
   logic [1:0]        tempo;
   logic [NV*SW-1:0]  voice_sample;
   logic [NV-1:0]     voice_valid;
   logic              play, reset_player, generate_next_sample, new_sample_generated;
   logic              beat, clip, underrun;
   logic [1:0]        current_song;
   logic [SW-1:0]     sample_out;

   int checks = 0;
   int errors = 0;

   music_player_core #(
      .NUM_SONGS(NS), .VOICES(NV), .SAMPLE_W(SW), .BEAT_COUNT(BC), .BEAT_W(BW)
   ) dut (
      .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
      .tempo(tempo), .song_done(song_done), .new_frame(new_frame),
      .voice_sample(voice_sample), .voice_valid(voice_valid),
      .play(play), .current_song(current_song), .reset_player(reset_player),
      .generate_next_sample(generate_next_sample),
      .new_sample_generated(new_sample_generated), .beat(beat),
      .sample_out(sample_out), .clip(clip), .underrun(underrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic pb, nb, sd;
      logic ep;
      int   es;
      logic erp;
   } row_t;
   row_t rows [18];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   function automatic int sout();
      logic signed [SW-1:0] s;
      s = sample_out;
      return int'(s);
   endfunction

   task automatic set_voice(input int i, input int val);
      voice_sample[i*SW +: SW] = SW'(val);
      voice_valid[i] = 1'b1;
   endtask

   // one frame: new_frame high 2 cycles, low 2 cycles
   task automatic frame(output int gens, output int beats, output int unds);
      gens = 0; beats = 0; unds = 0;
      for (int c = 0; c < 4; c++) begin
         new_frame = (c < 2);
         tick();
         gens  += int'(generate_next_sample);
         beats += int'(beat);
         unds  += int'(underrun);
         chk("nsg_eq_gns", int'(new_sample_generated), int'(generate_next_sample));
      end
      new_frame = 1'b0;
   endtask

   task automatic beat_run(input string nm, input int n, input int md, input int off);
      int g, b, u;
      for (int k = 0; k < n; k++) begin
         frame(g, b, u);
         chk({nm, "_gen"}, g, 1);
         chk({nm, "_beat"}, b, ((k + 1 + off) % md == 0) ? 1 : 0);
      end
   endtask

   task automatic press_play();
      play_button = 1'b1;
      tick();
      play_button = 1'b0;
   endtask

   initial begin
      int g, b, u;
      reset = 1'b0; play_button = 0; next_button = 0; song_done = 0; new_frame = 0;
      tempo = 2'b00; voice_sample = '0; voice_valid = '0;

      rows[0]  = '{1, 0, 0, 1, 0, 0};
      rows[1]  = '{0, 0, 0, 1, 0, 0};
      rows[2]  = '{1, 0, 0, 0, 0, 0};
      rows[3]  = '{0, 1, 0, 0, 1, 1};
      rows[4]  = '{0, 0, 0, 0, 1, 0};
      rows[5]  = '{1, 0, 0, 1, 1, 0};
      rows[6]  = '{1, 0, 1, 0, 2, 1};
      rows[7]  = '{0, 0, 0, 0, 2, 0};
      rows[8]  = '{1, 0, 0, 1, 2, 0};
      rows[9]  = '{1, 1, 1, 0, 3, 1};
      rows[10] = '{1, 0, 0, 0, 3, 0};
      rows[11] = '{0, 1, 0, 0, 0, 1};
      rows[12] = '{0, 1, 0, 0, 0, 0};
      rows[13] = '{0, 0, 1, 0, 0, 0};
      rows[14] = '{0, 1, 0, 0, 1, 1};
      rows[15] = '{0, 0, 0, 0, 1, 0};
      rows[16] = '{1, 1, 0, 0, 2, 1};
      rows[17] = '{0, 0, 0, 0, 2, 0};

      repeat (3) tick();
      chk("rst_play", int'(play), 0);
      chk("rst_song", int'(current_song), 0);
      chk("rst_reset_player", int'(reset_player), 0);
      chk("rst_gen", int'(generate_next_sample), 0);
      chk("rst_beat", int'(beat), 0);
      chk("rst_sample", sout(), 0);
      chk("rst_clip_underrun", int'({clip, underrun}), 0);
      reset = 1'b1;
      tick();

      for (int r = 0; r < 18; r++) begin
         play_button = rows[r].pb;
         next_button = rows[r].nb;
         song_done   = rows[r].sd;
         tick();
         play_button = 0; next_button = 0; song_done = 0;
         chk($sformatf("row%0d_play", r), int'(play), int'(rows[r].ep));
         chk($sformatf("row%0d_song", r), int'(current_song), rows[r].es);
         chk($sformatf("row%0d_reset_player", r), int'(reset_player), int'(rows[r].erp));
      end

      // beat generator
      press_play();
      chk("beat_play_on", int'(play), 1);
      tempo = 2'b00; beat_run("t00", 16, 8, 0);
      tempo = 2'b01; beat_run("t01", 8, 4, 0);
      tempo = 2'b10; beat_run("t10", 16, 16, 0);
      tempo = 2'b00; beat_run("t00_pre", 3, 8, 0);
      press_play();
      chk("beat_paused", int'(play), 0);
      beat_run("paused", 4, 1000, 0);
      press_play();
      beat_run("resume", 5, 8, 3);
      beat_run("pre_switch", 5, 8, 0);
      tempo = 2'b01;
      beat_run("switch", 1, 1, 0);
      beat_run("after_switch", 4, 4, 0);
      tempo = 2'b00;

      // mixer: positive saturation
      set_voice(0, 100000); set_voice(1, 100000); set_voice(2, 50000);
      tick(); voice_valid = '0;
      chk("sat_clip_early", int'(clip), 0);
      tick();
      chk("sat_clip", int'(clip), 1);
      tick();
      chk("sat_clip_off", int'(clip), 0);
      frame(g, b, u);
      chk("sat_underrun", u, 0);
      chk("sat_out", sout(), 131071);

      // overwrite and small signed sum
      set_voice(0, 999); tick(); voice_valid = '0;
      set_voice(0, -5);  tick(); voice_valid = '0;
      set_voice(1, 7);   tick(); voice_valid = '0;
      set_voice(2, 1);   tick(); voice_valid = '0;
      tick();
      chk("small_clip", int'(clip), 0);
      frame(g, b, u);
      chk("small_underrun", u, 0);
      chk("small_out", sout(), 3);

      // negative saturation
      set_voice(0, -100000); set_voice(1, -100000); set_voice(2, -1);
      tick(); voice_valid = '0;
      tick();
      chk("neg_clip", int'(clip), 1);
      frame(g, b, u);
      chk("neg_out", sout(), -131072);

      // underrun: two of three voices
      set_voice(0, 11); set_voice(1, 22);
      tick(); voice_valid = '0;
      repeat (2) tick();
      frame(g, b, u);
      chk("ur_underrun", u, 1);
      chk("ur_hold", sout(), -131072);
      set_voice(0, 1); set_voice(1, 2); set_voice(2, 3);
      tick(); voice_valid = '0;
      tick();
      frame(g, b, u);
      chk("ur_recover_underrun", u, 0);
      chk("ur_recover_out", sout(), 6);

      // muting while paused
      press_play();
      chk("mute_paused", int'(play), 0);
      set_voice(0, 500); set_voice(1, 600); set_voice(2, 700);
      tick(); voice_valid = '0;
      tick();
      frame(g, b, u);
      chk("mute_underrun", u, 0);
      chk("mute_out", sout(), 0);

      // reset mid-frame discards the partial mix
      press_play();
      set_voice(0, 40); set_voice(1, 50); set_voice(2, 60);
      tick(); voice_valid = '0;
      tick();
      frame(g, b, u);
      chk("pre_rst_out", sout(), 150);
      set_voice(0, 9);
      tick(); voice_valid = '0;
      reset = 1'b0;
      repeat (2) tick();
      chk("midrst_play", int'(play), 0);
      chk("midrst_sample", sout(), 0);
      reset = 1'b1;
      set_voice(1, 9); set_voice(2, 9);
      tick(); voice_valid = '0;
      repeat (2) tick();
      frame(g, b, u);
      chk("midrst_underrun", u, 1);
      chk("midrst_out", sout(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/music_player_core.md
# music_player_core

Parametrised transport, timing and mixing core for the music player. It holds the play/pause/next song state, derives the one-cycle codec sample request from the raw `new_frame`, and runs a tempo-selectable beat generator. It collects one sample per frame from `VOICES` independent note/chord players, sums them with saturation, and presents the result to the codec aligned to the frame. It replaces the fixed-function mcu/beat/conditioner glue with one block that supports N songs, N voices and tempo modes.

## Interface
Parameters:
- `NUM_SONGS`, 4: songs in ROM; ≥2.
- `VOICES`, 3: number of voice sample inputs; ≥1.
- `SAMPLE_W`, 18: signed sample width.
- `BEAT_COUNT`, 1000: sample requests per beat at normal tempo; even, ≥4.
- `BEAT_W`, 11: beat counter width; must hold 2*BEAT_COUNT-1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `play_button` in 1: debounced one-pulse; toggles play.
- `next_button` in 1: debounced one-pulse; advance song.
- `tempo` in 2: 00 normal, 01 double speed, 10 half speed, 11 normal.
- `song_done` in 1: one-cycle pulse from song reader.
- `new_frame` in 1: raw codec frame strobe; may stay high for several cycles.
- `voice_sample` in VOICES*SAMPLE_W: signed samples; voice i at bits [i*SAMPLE_W +: SAMPLE_W].
- `voice_valid` in VOICES: per-voice one-cycle strobe qualifying `voice_sample`.
- `play` out 1: high while playing.
- `current_song` out $clog2(NUM_SONGS): selected song.
- `reset_player` out 1: one-cycle pulse to reset the song reader.
- `generate_next_sample` out 1: one-cycle pulse on each `new_frame` rising edge.
- `new_sample_generated` out 1: identical to `generate_next_sample`.
- `beat` out 1: one-cycle beat pulse.
- `sample_out` out SAMPLE_W: frame-synced mixed sample.
- `clip` out 1: pulse when a mix saturated.
- `underrun` out 1: pulse when a frame had no complete mix.

## Operation
Transport FSM, states PAUSED, PLAYING, NEXT:
- PAUSED, `play_button` -> PLAYING.
- PLAYING, `play_button` -> PAUSED.
- PAUSED or PLAYING, `next_button` -> NEXT.
- PLAYING, `song_done` -> NEXT.
- NEXT lasts one cycle, then goes to PAUSED.
- On NEXT entry, `current_song` increments, wrapping from NUM_SONGS-1 to 0. `reset_player` is high for exactly the NEXT cycle.
- Priority within a cycle: `next_button` > `song_done` > `play_button`. Inputs arriving in NEXT are ignored.
- `play` = (state == PLAYING).

Frame sync:
- `new_frame` is registered once.
- `generate_next_sample` = `new_frame` & ~`new_frame_q`.
- The pulse fires regardless of `play`.

Beat generator:
- Stop value: BEAT_COUNT (normal), BEAT_COUNT/2 (tempo 01), 2*BEAT_COUNT (tempo 10). It is sampled every cycle.
- The counter advances only on `generate_next_sample` while `play`=1; otherwise it holds.
- On an advance with count ≥ stop-1: `beat`=1 that cycle and count returns to 0. Otherwise count increments.
- A tempo change to a smaller stop while count ≥ new stop-1 produces a beat on the next advance.

Mixer:
- Per voice, `voice_valid[i]` captures `voice_sample` into a register and sets a `seen[i]` flag.
- A repeated valid overwrites the register.
- The cycle after all `seen` bits are set: the sum is computed at SAMPLE_W+$clog2(VOICES)+1 bits and saturated to SAMPLE_W signed range. The result is written to `pending`, and `pending_ok` is set.
- `clip` pulses in that same cycle if saturation occurred.
- While `play`=0, the sum is forced to 0.

Frame output, on `generate_next_sample`:
- If `pending_ok`=1: `sample_out` <= `pending`.
- If `pending_ok`=0: `sample_out` holds its value and `underrun` pulses.
- In both cases all `seen` bits and `pending_ok` clear.
- A `voice_valid` arriving in the same cycle as `generate_next_sample` counts toward the new frame.

## Timing
- Reset, while `reset`=0 at a `clk` edge:
  - state PAUSED, `current_song`=0, beat count 0, `seen`=0, `pending`=0, `pending_ok`=0, `new_frame_q`=0.
  - All outputs are 0.
  - Reset mid-frame discards any partial mix.
- Button to `play`: 1 cycle latency.
- `next_button` to `reset_player`: 1 cycle. `current_song` updates in the same cycle as `reset_player`.
- `new_frame` rising edge to `generate_next_sample`: 1 cycle.
- `generate_next_sample` to `sample_out` update: 1 cycle. `beat` is coincident with `generate_next_sample`.
- Last `voice_valid` to `pending_ok`: 2 cycles. A mix that completes in the same cycle as `generate_next_sample` belongs to the old frame only if `pending_ok` was already set; otherwise that frame underruns.

## Test plan
- Reset and buttons: reset low 3 cycles, then play pulse -> `play`=1 after 1 cycle. Next pulse -> `current_song` 0->1, `reset_player` high 1 cycle, `play`=0. Four nexts with NUM_SONGS=4 -> `current_song` returns to 0.
- Priority: `song_done` and `play_button` in the same PLAYING cycle -> NEXT taken, then PAUSED, song advances.
- Beat tempo: BEAT_COUNT=8, play, `new_frame` every 4 cycles held 2 cycles high.
  - `generate_next_sample` is 1 cycle per frame.
  - `beat` fires every 8 frames (tempo 00), every 4 (01), every 16 (10).
  - With play=0, no beats and count held.
- Mix/saturation: VOICES=3, samples 100000, 100000, 50000 (SAMPLE_W=18) -> `sample_out`=131071, `clip` pulsed. Samples -5, 7, 1 -> `sample_out`=3.
- Underrun: only 2 of 3 voices valid before a frame -> `underrun` pulses, `sample_out` unchanged. The next complete frame is output normally.
- Pause muting: all voices valid with nonzero samples while `play`=0 -> `sample_out`=0 after the next frame.
